// File: rtl/sync_ram_pkg.sv
// Shared types and byte-lane helpers for sync_ram_2r1w and its read ports.
package sync_ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              be
  );
    return be ? new_b : old_b;
  endfunction

  // Even parity: the stored bit makes the lane plus parity have an even popcount.
  function automatic logic lane_par(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sync_ram_rd_port.sv
// Registered read port: write-first bypass, byte merge, data/valid registers.
// Parity check output is present only when SYNC_RAM_PARITY_EN is defined.
module sync_ram_rd_port
  import sync_ram_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 4,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [DATA_W-1:0] wr_data,
`ifdef SYNC_RAM_PARITY_EN
  input  logic [BE_W-1:0]   rd_par,
  input  logic [BE_W-1:0]   wr_par,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic              hit;
  logic [DATA_W-1:0] merged;

  assign hit = wr_en && (wr_addr == rd_addr);

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign merged[BYTE_W*i +: BYTE_W] =
      merge_byte(rd_word[BYTE_W*i +: BYTE_W], wr_data[BYTE_W*i +: BYTE_W], hit & wr_be[i]);
  end

`ifdef SYNC_RAM_PARITY_EN
  logic [BE_W-1:0] merged_par, chk;
  for (genvar i = 0; i < BE_W; i++) begin : g_par
    assign merged_par[i] = (hit & wr_be[i]) ? wr_par[i] : rd_par[i];
    assign chk[i]        = lane_par(merged[BYTE_W*i +: BYTE_W]) ^ merged_par[i];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef SYNC_RAM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= merged;
`ifdef SYNC_RAM_PARITY_EN
        par_err <= |chk;
`endif
      end
    end
  end

endmodule

// File: rtl/sync_ram_2r1w.sv
// 1W/2R synchronous RAM with byte enables, write-first bypass and a clear engine.
// Optional per-lane even parity and error injection under SYNC_RAM_PARITY_EN.
module sync_ram_2r1w
  import sync_ram_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 4,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
`ifdef SYNC_RAM_PARITY_EN
  input  logic              wr_par_flip,
  output logic              par_err_a,
  output logic              par_err_b,
`endif
  output logic              rd_valid_a,
  output logic              rd_valid_b
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NUM_RD = 2;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Clear walks 0..DEPTH-1 once and stops; clr_req only counts in IDLE.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    busy         = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_addr == {ADDR_W{1'b1}}) state_nxt = ST_IDLE;
        else                            clr_addr_nxt = clr_addr + 1'b1;
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt    = ST_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_act;
  logic [DATA_W-1:0] wr_old, wr_word;

  assign wr_act = wr_en & ~busy;
  assign wr_old = mem[wr_addr];

  for (genvar i = 0; i < BE_W; i++) begin : g_wr_lane
    assign wr_word[BYTE_W*i +: BYTE_W] =
      merge_byte(wr_old[BYTE_W*i +: BYTE_W], wr_data[BYTE_W*i +: BYTE_W], wr_be[i]);
  end

  always_ff @(posedge clk) begin
    if (busy)        mem[clr_addr] <= '0;
    else if (wr_act) mem[wr_addr]  <= wr_word;
  end

`ifdef SYNC_RAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] wr_par, wr_par_old, wr_par_word;

  assign wr_par_old = par_mem[wr_addr];

  for (genvar i = 0; i < BE_W; i++) begin : g_wr_par
    assign wr_par[i]      = lane_par(wr_data[BYTE_W*i +: BYTE_W]) ^ wr_par_flip;
    assign wr_par_word[i] = wr_be[i] ? wr_par[i] : wr_par_old[i];
  end

  always_ff @(posedge clk) begin
    if (busy)        par_mem[clr_addr] <= '0;
    else if (wr_act) par_mem[wr_addr]  <= wr_par_word;
  end
`endif

  logic [NUM_RD-1:0]             rd_en_v, rd_valid_v;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_v;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_word_v, rd_data_v;

  assign rd_en_v   = {rd_en_b, rd_en_a} & {NUM_RD{~busy}};
  assign rd_addr_v = {rd_addr_b, rd_addr_a};

`ifdef SYNC_RAM_PARITY_EN
  logic [NUM_RD-1:0][BE_W-1:0] rd_par_v;
  logic [NUM_RD-1:0]           par_err_v;
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_word_v[p] = mem[rd_addr_v[p]];
`ifdef SYNC_RAM_PARITY_EN
    assign rd_par_v[p]  = par_mem[rd_addr_v[p]];
`endif
    sync_ram_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en_v[p]),
      .rd_addr  (rd_addr_v[p]),
      .rd_word  (rd_word_v[p]),
      .wr_en    (wr_act),
      .wr_addr  (wr_addr),
      .wr_be    (wr_be),
      .wr_data  (wr_data),
`ifdef SYNC_RAM_PARITY_EN
      .rd_par   (rd_par_v[p]),
      .wr_par   (wr_par),
      .par_err  (par_err_v[p]),
`endif
      .rd_data  (rd_data_v[p]),
      .rd_valid (rd_valid_v[p])
    );
  end

  assign rd_data_a  = rd_data_v[0];
  assign rd_data_b  = rd_data_v[1];
  assign rd_valid_a = rd_valid_v[0];
  assign rd_valid_b = rd_valid_v[1];
`ifdef SYNC_RAM_PARITY_EN
  assign par_err_a  = par_err_v[0];
  assign par_err_b  = par_err_v[1];
`endif

endmodule
